// File: rtl/score_pkg.sv
// -----------------------------------------------------------------------------
// score_pkg
// Shared types and constants for the score_keeper scoreboard:
//   - state_t          : accumulator FSM states
//   - SEG7_TABLE       : active-low {g..a} segment codes for BCD digits 0-9
//   - SEG7_BLANK       : all segments off, shown for non-BCD nibbles
//   - BCD_NINE         : saturation value of one digit
//   - kills_width()    : bit width needed to count 0..n_enemies kills
// -----------------------------------------------------------------------------
package score_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ADD   = 2'd2,
        BONUS = 2'd3
    } state_t;

    localparam logic [3:0] BCD_NINE = 4'd9;

    localparam logic [6:0] SEG7_BLANK = 7'h7F;

    localparam logic [6:0] SEG7_TABLE [10] = '{
        7'h40,  // 0
        7'h79,  // 1
        7'h24,  // 2
        7'h30,  // 3
        7'h19,  // 4
        7'h12,  // 5
        7'h02,  // 6
        7'h78,  // 7
        7'h00,  // 8
        7'h10   // 9
    };

    function automatic int kills_width(input int n_enemies);
        return (n_enemies < 1) ? 1 : $clog2(n_enemies + 1);
    endfunction

endpackage

// File: rtl/bcd_seg7.sv
// -----------------------------------------------------------------------------
// bcd_seg7
// Combinational BCD digit to 7-segment decoder (active-low, {g..a}).
// Ports:
//   i_bcd : 4-bit BCD digit
//   o_seg : segment drive, 0 = segment lit; nibbles above 9 blank the digit
// -----------------------------------------------------------------------------
module bcd_seg7
    import score_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG7_BLANK;
        if (i_bcd <= 4'd9) begin
            o_seg = SEG7_TABLE[i_bcd];
        end
    end

endmodule

// File: rtl/score_keeper.sv
// -----------------------------------------------------------------------------
// score_keeper
// Scoreboard for the shooter game. Enemy deaths are seen as falling edges of
// enemy_alive, latched into a pending mask and serviced one at a time by a
// digit-serial BCD adder. A one-time bonus is added when every enemy of the
// current wave has been killed. The score saturates at all 9s.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high
//   pausa          freezes the FSM and datapath; edge capture keeps running
//   enemy_alive    one bit per enemy, 1 = alive
//   wave_start     one-cycle pulse, clears the wave kill count and bonus flag
//   score_bcd      BCD score, digit 0 in the LSBs
//   hex            registered active-low 7-segment drive per digit
//   kills_in_wave  kills serviced in the current wave (saturating)
//   busy           FSM not idle or kills still pending
//   saturated      sticky flag, score clamped at all 9s
//
// Optional feature (macro SCORE_KEEPER_HISCORE_EN):
//   show_hi        input, display the high score instead of the score
//   hiscore_bcd    output, best score seen; survives reset
// -----------------------------------------------------------------------------
module score_keeper
    import score_pkg::*;
#(
    parameter int N_ENEMIES       = 5,
    parameter int N_DIGITS        = 4,
    parameter int POINTS_PER_KILL = 1,
    parameter int WAVE_BONUS      = 5
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 pausa,
    input  logic [N_ENEMIES-1:0]                 enemy_alive,
    input  logic                                 wave_start,
    output logic [4*N_DIGITS-1:0]                score_bcd,
    output logic [7*N_DIGITS-1:0]                hex,
    output logic [kills_width(N_ENEMIES)-1:0]    kills_in_wave,
    output logic                                 busy,
    output logic                                 saturated
`ifdef SCORE_KEEPER_HISCORE_EN
    ,
    input  logic                                 show_hi,
    output logic [4*N_DIGITS-1:0]                hiscore_bcd
`endif
);

    localparam int KW = kills_width(N_ENEMIES);
    localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int SW = 4 * N_DIGITS;

    localparam logic [KW-1:0] KILLS_MAX  = KW'(N_ENEMIES);
    localparam logic [DW-1:0] LAST_DIGIT = DW'(N_DIGITS - 1);
    localparam logic [3:0]    PPK        = 4'(POINTS_PER_KILL);
    localparam logic [3:0]    BONUS_PTS  = 4'(WAVE_BONUS);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [N_ENEMIES-1:0]   r_prev_alive;
    logic [N_ENEMIES-1:0]   r_pending;
    logic [N_ENEMIES-1:0]   w_kill_evt;
    logic [N_ENEMIES-1:0]   w_lowest;
    logic [N_ENEMIES-1:0]   w_load_clr;
    logic [SW-1:0]          r_score;
    logic [SW-1:0]          w_score_add;
    logic [SW-1:0]          w_disp;
    logic [3:0]             r_addend;
    logic [3:0]             w_cur_digit;
    logic [4:0]             w_sum;
    logic                   w_carry_out;
    logic                   w_last;
    logic                   r_carry;
    logic [DW-1:0]          r_digit;
    logic [KW-1:0]          r_kills;
    logic                   r_bonus_done;
    logic                   r_saturated;
    logic [7*N_DIGITS-1:0]  r_hex;
    logic [7*N_DIGITS-1:0]  w_hex;
    logic                   w_do_load;
    logic                   w_do_bonus;
    logic                   w_do_add;

    // Edge capture: falling edges only; never paused so no kill is lost.
    assign w_kill_evt = r_prev_alive & ~enemy_alive;
    // Isolate the lowest set pending bit (two's-complement trick).
    assign w_lowest   = r_pending & (~r_pending + N_ENEMIES'(1));
    assign w_load_clr = w_do_load ? w_lowest : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_alive <= '0;
            r_pending    <= '0;
        end else begin
            r_prev_alive <= enemy_alive;
            r_pending    <= (r_pending | w_kill_evt) & ~w_load_clr;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and per-state strobes; pausa holds everything.
    // A saturated score skips ADD entirely, but LOAD still counts the kill.
    always_comb begin
        w_state_nxt = r_state;
        w_do_load   = 1'b0;
        w_do_bonus  = 1'b0;
        w_do_add    = 1'b0;
        if (!pausa) begin
            case (r_state)
                IDLE: begin
                    if (r_pending != '0) begin
                        w_state_nxt = LOAD;
                    end else if ((r_kills == KILLS_MAX) && !r_bonus_done &&
                                 (BONUS_PTS != 4'd0)) begin
                        w_state_nxt = BONUS;
                    end
                end
                LOAD: begin
                    w_do_load   = 1'b1;
                    w_state_nxt = r_saturated ? IDLE : ADD;
                end
                BONUS: begin
                    w_do_bonus  = 1'b1;
                    w_state_nxt = r_saturated ? IDLE : ADD;
                end
                ADD: begin
                    w_do_add = 1'b1;
                    if (r_digit == LAST_DIGIT) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Digit-serial adder: only digit 0 receives the addend, higher digits
    // just absorb the ripple carry.
    always_comb begin
        w_cur_digit = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_digit == DW'(i)) begin
                w_cur_digit = r_score[4*i +: 4];
            end
        end
        w_sum       = {1'b0, w_cur_digit}
                    + {1'b0, (r_digit == '0) ? r_addend : 4'd0}
                    + {4'd0, r_carry};
        w_carry_out = (w_sum > 5'd9);
        w_score_add = r_score;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_digit == DW'(i)) begin
                w_score_add[4*i +: 4] = w_carry_out ? 4'(w_sum - 5'd10) : w_sum[3:0];
            end
        end
    end

    assign w_last = (r_digit == LAST_DIGIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_score      <= '0;
            r_addend     <= '0;
            r_carry      <= 1'b0;
            r_digit      <= '0;
            r_kills      <= '0;
            r_bonus_done <= 1'b0;
            r_saturated  <= 1'b0;
        end else begin
            if (w_do_load) begin
                r_addend <= PPK;
                r_digit  <= '0;
                r_carry  <= 1'b0;
                if (r_kills != KILLS_MAX) begin
                    r_kills <= r_kills + KW'(1);
                end
            end
            if (w_do_bonus) begin
                r_addend     <= BONUS_PTS;
                r_bonus_done <= 1'b1;
                r_digit      <= '0;
                r_carry      <= 1'b0;
            end
            if (w_do_add) begin
                if (w_last) begin
                    // Carry out of the top digit: clamp instead of wrapping.
                    if (w_carry_out) begin
                        r_score     <= {N_DIGITS{BCD_NINE}};
                        r_saturated <= 1'b1;
                    end else begin
                        r_score <= w_score_add;
                    end
                    r_carry <= 1'b0;
                end else begin
                    r_score <= w_score_add;
                    r_carry <= w_carry_out;
                    r_digit <= r_digit + DW'(1);
                end
            end
            // A new wave overrides the LOAD increment; a coincident LOAD
            // still counts as the first kill of the new wave.
            if (wave_start) begin
                r_kills      <= w_do_load ? KW'(1) : '0;
                r_bonus_done <= 1'b0;
            end
        end
    end

`ifdef SCORE_KEEPER_HISCORE_EN
    // Deliberately outside reset so the best score survives a game restart.
    logic [SW-1:0] r_hiscore = '0;

    always_ff @(posedge clk) begin
        if (!pausa && (r_state == IDLE) && (r_score > r_hiscore)) begin
            r_hiscore <= r_score;
        end
    end

    assign hiscore_bcd = r_hiscore;
    assign w_disp      = show_hi ? r_hiscore : r_score;
`else
    assign w_disp = r_score;
`endif

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_seg
        bcd_seg7 u_seg (
            .i_bcd (w_disp[4*g +: 4]),
            .o_seg (w_hex[7*g +: 7])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hex <= {N_DIGITS{SEG7_TABLE[0]}};
        end else begin
            r_hex <= w_hex;
        end
    end

    assign score_bcd     = r_score;
    assign hex           = r_hex;
    assign kills_in_wave = r_kills;
    assign busy          = (r_state != IDLE) || (r_pending != '0);
    assign saturated     = r_saturated;

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;

    localparam int NE  = 5;
    localparam int ND  = 4;
    localparam int PPK = 1;
    localparam int WB  = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main DUT (default parameters)
    logic          reset, pausa, wave_start;
    logic [NE-1:0] enemy_alive;
    logic [15:0]   score_bcd;
    logic [27:0]   hex;
    logic [2:0]    kills_in_wave;
    logic          busy, saturated;

    // saturation DUT (1 digit, 9 points per kill, 2 enemies, no bonus)
    logic          p2, s_wave;
    logic [1:0]    s_alive;
    logic [3:0]    s_score;
    logic [6:0]    s_hex;
    logic [1:0]    s_kills;
    logic          s_busy, s_sat;

`ifdef SCORE_KEEPER_HISCORE_EN
    logic          show_hi = 1'b0, s_show_hi = 1'b0;
    logic [15:0]   hiscore_bcd;
    logic [3:0]    s_hiscore;
`endif

    score_keeper #(.N_ENEMIES(NE), .N_DIGITS(ND), .POINTS_PER_KILL(PPK), .WAVE_BONUS(WB)) dut (
        .clk           (clk),
        .reset         (reset),
        .pausa         (pausa),
        .enemy_alive   (enemy_alive),
        .wave_start    (wave_start),
        .score_bcd     (score_bcd),
        .hex           (hex),
        .kills_in_wave (kills_in_wave),
        .busy          (busy),
        .saturated     (saturated)
`ifdef SCORE_KEEPER_HISCORE_EN
        ,
        .show_hi       (show_hi),
        .hiscore_bcd   (hiscore_bcd)
`endif
    );

    score_keeper #(.N_ENEMIES(2), .N_DIGITS(1), .POINTS_PER_KILL(9), .WAVE_BONUS(0)) dut_sat (
        .clk           (clk),
        .reset         (reset),
        .pausa         (p2),
        .enemy_alive   (s_alive),
        .wave_start    (s_wave),
        .score_bcd     (s_score),
        .hex           (s_hex),
        .kills_in_wave (s_kills),
        .busy          (s_busy),
        .saturated     (s_sat)
`ifdef SCORE_KEEPER_HISCORE_EN
        ,
        .show_hi       (s_show_hi),
        .hiscore_bcd   (s_hiscore)
`endif
    );

    int checks, errors;
    int m_score, m_kills, m_bonus_done;
    logic [NE-1:0] m_prev;
    int busy_cnt;
    logic [NE-1:0] nv;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [27:0] hex_of(input int v);
        logic [27:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[7*i +: 7] = seg_of(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Reference: every falling edge is one kill worth PPK points; the wave
    // count saturates at NE; reaching NE kills earns WB once per wave.
    task automatic apply_model(input logic [NE-1:0] v);
        int n;
        n = $countones(m_prev & ~v);
        m_kills = (m_kills + n > NE) ? NE : m_kills + n;
        m_score = m_score + n * PPK;
        if (m_kills == NE && m_bonus_done == 0 && WB != 0) begin
            m_score      = m_score + WB;
            m_bonus_done = 1;
        end
        m_prev = v;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input bit sel);
        int quiet, n;
        quiet = 0;
        n = 0;
        while (quiet < 2 && n < 1000) begin
            tick();
            n++;
            if ((sel ? s_busy : busy) == 1'b0) quiet++;
            else quiet = 0;
        end
        check(sel ? "idle_sat_timeout" : "idle_timeout", 32'(quiet >= 2), 1);
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; pausa = 1'b0; wave_start = 1'b0; enemy_alive = '0;
        p2 = 1'b0; s_wave = 1'b0; s_alive = '0;
        m_score = 0; m_kills = 0; m_bonus_done = 0; m_prev = '0;

        tick(); tick();
        check("rst_score", score_bcd, 0);
        check("rst_hex", hex, hex_of(0));
        check("rst_kills", kills_in_wave, 0);
        check("rst_busy", busy, 0);
        check("rst_sat", saturated, 0);
        reset = 1'b0;

        // spawn: rising edges give no points
        enemy_alive = 5'b11111; apply_model(5'b11111);
        tick(); tick();
        check("spawn_score", score_bcd, 0);
        check("spawn_busy", busy, 0);

        // single kill of enemy 2
        enemy_alive = 5'b11011; apply_model(5'b11011);
        repeat (6) tick();
        check("kill1_score", score_bcd, 16'h0001);
        check("kill1_kills", kills_in_wave, 1);
        tick();
        check("kill1_hex0", hex[6:0], 7'b1111001);
        wait_idle(0);

        // enemies 0, 1, 4 die together: three sequential services
        enemy_alive = 5'b01000; apply_model(5'b01000);
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy) busy_cnt++;
        end
        check("multi_busy_cycles", busy_cnt, 18);
        check("multi_score", score_bcd, to_bcd(m_score));
        check("multi_kills", kills_in_wave, 4);

        // last enemy: wave cleared, bonus added once
        enemy_alive = 5'b00000; apply_model(5'b00000);
        wait_idle(0);
        check("bonus_score", score_bcd, 16'h0010);
        check("bonus_model", score_bcd, to_bcd(m_score));
        check("bonus_kills", kills_in_wave, 5);
        repeat (20) tick();
        check("bonus_once", score_bcd, 16'h0010);
        check("bonus_hex", hex, hex_of(10));

        // new wave with respawn
        wave_start = 1'b1; enemy_alive = 5'b11111;
        tick();
        wave_start = 1'b0;
        m_kills = 0; m_bonus_done = 0; apply_model(5'b11111);
        tick();
        check("wave_kills", kills_in_wave, 0);
        check("wave_score", score_bcd, 16'h0010);

        // pause during ADD while enemy 2 dies
        enemy_alive = 5'b11110; apply_model(5'b11110);
        repeat (3) tick();
        pausa = 1'b1;
        tick();
        enemy_alive = 5'b11010; apply_model(5'b11010);
        repeat (9) tick();
        check("pause_frozen", score_bcd, 16'h0010);
        check("pause_busy", busy, 1);
        check("pause_kills", kills_in_wave, 1);
        pausa = 1'b0;
        wait_idle(0);
        check("pause_score", score_bcd, to_bcd(m_score));
        check("pause_kills_after", kills_in_wave, 2);

        // saturation on the single-digit instance
        s_alive = 2'b11; tick(); tick();
        s_alive = 2'b10; wait_idle(1);
        check("sat1_score", s_score, 9);
        check("sat1_flag", s_sat, 0);
        s_alive = 2'b00; wait_idle(1);
        check("sat2_score", s_score, 9);
        check("sat2_flag", s_sat, 1);
        check("sat2_hex", s_hex, 7'b0010000);
        s_alive = 2'b11; tick(); tick();
        s_alive = 2'b01; wait_idle(1);
        check("sat3_score", s_score, 9);
        check("sat3_kills", s_kills, 2);
        check("sat3_flag", s_sat, 1);

        // randomized kill/respawn patterns against the model
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                wave_start = 1'b1;
                tick();
                wave_start = 1'b0;
                m_kills = 0; m_bonus_done = 0;
            end
            nv = NE'($urandom);
            enemy_alive = nv; apply_model(nv);
            wait_idle(0);
            check("rand_score", score_bcd, to_bcd(m_score));
            check("rand_kills", kills_in_wave, m_kills);
            check("rand_hex", hex, hex_of(m_score));
            check("rand_sat", saturated, 0);
        end

        // reset lands while digit 2 is being added
        enemy_alive = 5'b11111; apply_model(5'b11111);
        wait_idle(0);
        enemy_alive = 5'b01111;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        check("midrst_score", score_bcd, 0);
        check("midrst_busy", busy, 0);
        check("midrst_kills", kills_in_wave, 0);
        check("midrst_hex", hex, hex_of(0));
        reset = 1'b0;
        tick(); tick();
        check("postrst_score", score_bcd, 0);
        check("postrst_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
